// File: rtl/opfetch_pkg.sv
// Shared types for the operand fetch slice: controller state encoding and
// the register-file capacity helper.
package opfetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic int cap_f(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle for operand_fetch: instruction input, operand output, writeback
// strobe and the register-file port. slave is the operand_fetch side.
interface operand_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rs1;
  logic [ADDR_WIDTH-1:0] in_rs2;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_wen;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_op1;
  logic [DATA_WIDTH-1:0] out_op2;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic                  out_wen;

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [ADDR_WIDTH-1:0] rf_r1_addr;
  logic [ADDR_WIDTH-1:0] rf_r2_addr;
  logic [ADDR_WIDTH-1:0] rf_write_addr;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic                  rf_write_ctrl;
  logic [DATA_WIDTH-1:0] rf_r1_out;
  logic [DATA_WIDTH-1:0] rf_r2_out;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wen,
    output in_ready,
    output out_valid, out_op1, out_op2, out_rd, out_wen,
    input  out_ready,
    input  wb_valid, wb_addr, wb_data,
    output rf_r1_addr, rf_r2_addr, rf_write_addr, rf_write_data, rf_write_ctrl,
    input  rf_r1_out, rf_r2_out
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_wen,
    input  in_ready,
    input  out_valid, out_op1, out_op2, out_rd, out_wen,
    output out_ready,
    output wb_valid, wb_addr, wb_data,
    input  rf_r1_addr, rf_r2_addr, rf_write_addr, rf_write_data, rf_write_ctrl,
    output rf_r1_out, rf_r2_out
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard with three combinational lookups. Defining
// OPFETCH_WB_BYPASS_EN lets a same-cycle writeback hide its busy bit.
module reg_scoreboard
  import opfetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] look_a_addr,
  input  logic [ADDR_WIDTH-1:0] look_b_addr,
  input  logic [ADDR_WIDTH-1:0] look_c_addr,
  output logic                  look_a_busy,
  output logic                  look_b_busy,
  output logic                  look_c_busy
);

  localparam int CAP = cap_f(ADDR_WIDTH);

  logic [CAP-1:0] busy;

  // The set is written last so it wins over a clear of the same entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

`ifdef OPFETCH_WB_BYPASS_EN
  assign look_a_busy = busy[look_a_addr] && !(clr_en && clr_addr == look_a_addr);
  assign look_b_busy = busy[look_b_addr] && !(clr_en && clr_addr == look_b_addr);
  assign look_c_busy = busy[look_c_addr] && !(clr_en && clr_addr == look_c_addr);
`else
  assign look_a_busy = busy[look_a_addr];
  assign look_b_busy = busy[look_b_addr];
  assign look_c_busy = busy[look_c_addr];
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch front end: issues both source reads, returns the operand pair
// and stalls on scoreboard hazards (writeback bypass via OPFETCH_WB_BYPASS_EN).
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic           clock,
  input logic           reset_n,
  operand_fetch_if.slave bus
);

  state_t state, state_next;

  logic                  hazard;
  logic                  accept;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  busy_rs1, busy_rs2, busy_rd;
  logic [ADDR_WIDTH-1:0] pend_rd;
  logic                  pend_wen;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wen_q;

  assign bus.rf_write_ctrl = bus.wb_valid;
  assign bus.rf_write_addr = bus.wb_addr;
  assign bus.rf_write_data = bus.wb_data;
  assign bus.rf_r1_addr    = bus.in_rs1;
  assign bus.rf_r2_addr    = bus.in_rs2;

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .set_en      (accept && bus.in_wen),
    .set_addr    (bus.in_rd),
    .clr_en      (bus.wb_valid),
    .clr_addr    (bus.wb_addr),
    .look_a_addr (bus.in_rs1),
    .look_b_addr (bus.in_rs2),
    .look_c_addr (bus.in_rd),
    .look_a_busy (busy_rs1),
    .look_b_busy (busy_rs2),
    .look_c_busy (busy_rd)
  );

  assign hazard = busy_rs1 || busy_rs2 || (bus.in_wen && busy_rd);
  assign accept = bus.in_valid && in_ready_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = FETCH;
      FETCH:   state_next = OUT;
      OUT:     if (bus.out_ready) state_next = accept ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid_c = (state == OUT);
    in_ready_c  = ((state == IDLE) || (state == OUT && bus.out_ready)) && !hazard;
  end

  // rd/wen are captured at accept because the input may move on during FETCH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_rd  <= '0;
      pend_wen <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
    end else begin
      if (accept) begin
        pend_rd  <= bus.in_rd;
        pend_wen <= bus.in_wen;
      end
      if (state == FETCH) begin
        op1_q <= bus.rf_r1_out;
        op2_q <= bus.rf_r2_out;
        rd_q  <= pend_rd;
        wen_q <= pend_wen;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_op1   = op1_q;
  assign bus.out_op2   = op2_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_wen   = wen_q;

endmodule
